// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and MMIO decode.
package dmem_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CPU_RD = 2'd1;
    localparam logic [1:0] ST_LD_RD  = 2'd2;

    localparam int MMIO_BIT = 31;

    // Address bit 31 selects the switch/LED window instead of RAM.
    function automatic logic is_mmio(input logic [31:0] addr);
        return addr[MMIO_BIT];
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port synchronous RAM between the CPU
// load/store port and the loader/debug port, and decodes the switch/LED MMIO
// window. Writes complete in the request cycle; reads spend one extra cycle in
// CPU_RD or LD_RD while the RAM produces its registered output.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_mem_read,
    input  logic              cpu_mem_write,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_gnt,
    output logic [31:0]       ld_rdata,
    output logic              ld_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       io_switch,
    output logic [15:0]       led
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [1:0]       state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             rd_mmio_r;
    logic [31:0]      cpu_rdata_r;
    logic [31:0]      ld_rdata_r;
    logic [15:0]      led_r;

    logic cpu_req_s;
    logic idle_s;
    logic ld_wins_s;
    logic cpu_wins_s;
    logic cpu_wr_s;
    logic cpu_rd_s;
    logic mmio_s;
    logic unused_addr_s;

    // Arbitration: CPU by default; loader when the CPU is idle or it has waited MAX_WAIT cycles.
    always_comb begin
        cpu_req_s  = cpu_mem_read | cpu_mem_write;
        idle_s     = (state_r == ST_IDLE);
        mmio_s     = is_mmio(cpu_addr);
        ld_wins_s  = idle_s & ld_req & (~cpu_req_s | (wait_cnt_r == CNT_MAX));
        cpu_wins_s = idle_s & cpu_req_s & ~ld_wins_s;
        // A simultaneous read+write request is served as a write.
        cpu_wr_s   = cpu_wins_s & cpu_mem_write;
        cpu_rd_s   = cpu_wins_s & ~cpu_mem_write;
    end

    // RAM port and handshake outputs; the address follows the CPU unless the loader is granted.
    always_comb begin
        if (ld_wins_s) begin
            ram_addr = ld_addr;
            ram_din  = ld_wdata;
        end else begin
            ram_addr = cpu_addr[ADDR_W-1:0];
            ram_din  = cpu_wdata;
        end
        ram_we     = (ld_wins_s & ld_we) | (cpu_wr_s & ~mmio_s);
        ld_gnt     = ld_wins_s;
        cpu_rvalid = (state_r == ST_CPU_RD);
        ld_rvalid  = (state_r == ST_LD_RD);
        cpu_stall  = cpu_req_s & ~cpu_wr_s & ~cpu_rvalid;
    end

    assign unused_addr_s = ^cpu_addr[MMIO_BIT-1:ADDR_W];

    assign cpu_rdata = cpu_rdata_r;
    assign ld_rdata  = ld_rdata_r;
    assign led       = led_r;

    // Access sequencer: launches reads, captures read data, and updates the LED register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            rd_mmio_r   <= 1'b0;
            cpu_rdata_r <= 32'h0000_0000;
            ld_rdata_r  <= 32'h0000_0000;
            led_r       <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ld_wins_s && !ld_we) begin
                        state_r <= ST_LD_RD;
                    end else if (cpu_rd_s) begin
                        state_r   <= ST_CPU_RD;
                        rd_mmio_r <= mmio_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                    if (cpu_wr_s && mmio_s) begin
                        led_r <= cpu_wdata[15:0];
                    end
                end
                ST_CPU_RD: begin
                    // MMIO reads sample the switches here so both read kinds share one latency.
                    if (rd_mmio_r) begin
                        cpu_rdata_r <= {16'h0000, io_switch};
                    end else begin
                        cpu_rdata_r <= ram_dout;
                    end
                    state_r <= ST_IDLE;
                end
                ST_LD_RD: begin
                    ld_rdata_r <= ram_dout;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Loader starvation counter: counts refused cycles, saturates, clears on grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (ld_gnt) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (ld_req && (wait_cnt_r != CNT_MAX)) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous RAM attached.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_mem_read, cpu_mem_write;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_rvalid, cpu_stall;
    logic        ld_req, ld_we, ld_gnt, ld_rvalid;
    logic [13:0] ld_addr, ram_addr;
    logic [31:0] ld_wdata, ld_rdata, ram_din, ram_dout;
    logic        ram_we;
    logic [15:0] io_switch, led;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:255];

    dmem_arbiter #(.ADDR_W(14), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .io_switch(io_switch), .led(led)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read, as the external IP behaves.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_din;
        ram_dout <= mem[ram_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int refused;
        logic got;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst = 1'b0; cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; ld_req = 1'b0; ld_we = 1'b0;
        ld_addr = 14'h0; ld_wdata = 32'h0; io_switch = 16'h0;
        tick(); tick();
        chk("rst_led", led, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_ld_rdata", ld_rdata, 32'h0);
        chk("rst_pulses", {ld_gnt, ld_rvalid, cpu_rvalid, ram_we}, 32'h0);
        rst = 1'b1;
        tick();

        // 1: RAM store then load
        cpu_mem_write = 1'b1; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_sw_we", ram_we, 32'h1);
        chk("t1_sw_stall", cpu_stall, 32'h0);
        chk("t1_sw_addr", ram_addr, 32'h10);
        tick();
        cpu_mem_write = 1'b0; cpu_mem_read = 1'b1;
        #1;
        chk("t1_lw_stall", {cpu_stall, cpu_rvalid}, 32'h2);
        tick();
        chk("t1_lw_rvalid", {cpu_stall, cpu_rvalid}, 32'h1);
        tick();
        cpu_mem_read = 1'b0;
        #1;
        chk("t1_lw_data", cpu_rdata, 32'hDEAD_BEEF);
        chk("t1_rvalid_drop", cpu_rvalid, 32'h0);

        // 2: MMIO LED write and switch read
        cpu_mem_write = 1'b1; cpu_addr = 32'h8000_0000; cpu_wdata = 32'h0000_A5A5;
        #1;
        chk("t2_sw_we", {ram_we, cpu_stall}, 32'h0);
        tick();
        cpu_mem_write = 1'b0; io_switch = 16'h1234; cpu_mem_read = 1'b1;
        #1;
        chk("t2_led", led, 32'hA5A5);
        chk("t2_lw_stall", cpu_stall, 32'h1);
        tick();
        chk("t2_lw_rvalid", cpu_rvalid, 32'h1);
        tick();
        cpu_mem_read = 1'b0;
        #1;
        chk("t2_lw_data", cpu_rdata, 32'h0000_1234);

        // 3: loader write then read, CPU idle
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 14'd5; ld_wdata = 32'h11;
        #1;
        chk("t3_wr_gnt", {ld_gnt, ram_we}, 32'h3);
        chk("t3_wr_addr", ram_addr, 32'h5);
        tick();
        ld_we = 1'b0;
        #1;
        chk("t3_rd_gnt", {ld_gnt, ram_we}, 32'h2);
        tick();
        ld_req = 1'b0;
        #1;
        chk("t3_rd_rvalid", {ld_rvalid, ld_gnt}, 32'h2);
        tick();
        chk("t3_rd_data", ld_rdata, 32'h11);

        // 4: CPU loops loads while loader waits
        cpu_mem_read = 1'b1; cpu_addr = 32'h0000_0010;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 14'd5;
        refused = 0; got = 1'b0;
        #1;
        for (int i = 0; i < 12 && !got; i++) begin
            if (ld_gnt === 1'b1) got = 1'b1;
            else begin
                refused++;
                tick(); #1;
            end
        end
        chk("t4_granted", {31'h0, got}, 32'h1);
        chk("t4_refused", refused, 32'd4);
        chk("t4_cpu_stalled", cpu_stall, 32'h1);
        tick();
        ld_req = 1'b0;
        #1;
        chk("t4_ld_rvalid", {ld_rvalid, cpu_stall}, 32'h3);
        tick();
        ld_req = 1'b1;
        #1;
        chk("t4_ld_rdata", ld_rdata, 32'h11);
        chk("t4_cnt_cleared", {ld_gnt, cpu_stall}, 32'h1);
        tick();
        chk("t4_cpu_rvalid", cpu_rvalid, 32'h1);
        tick();
        cpu_mem_read = 1'b0;
        #1;
        chk("t4_ld_idle_gnt", ld_gnt, 32'h1);
        tick();
        ld_req = 1'b0;
        tick();

        // 5: simultaneous CPU store and loader write, counter at zero
        cpu_mem_write = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'hCAFE_0001;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 14'd6; ld_wdata = 32'h66;
        #1;
        chk("t5_cpu_first", {ram_we, cpu_stall, ld_gnt}, 32'h4);
        chk("t5_cpu_addr", ram_addr, 32'h20);
        tick();
        cpu_mem_write = 1'b0;
        #1;
        chk("t5_ld_next", {ld_gnt, ram_we}, 32'h3);
        chk("t5_ld_addr", ram_addr, 32'h6);
        tick();
        ld_req = 1'b0; ld_we = 1'b0;
        cpu_mem_read = 1'b1; cpu_addr = 32'h0000_0006;
        tick();
        tick();
        cpu_mem_read = 1'b0;
        #1;
        chk("t5_readback", cpu_rdata, 32'h66);

        // 6: reset in CPU_RD abandons the read
        cpu_mem_read = 1'b1; cpu_addr = 32'h0000_0010;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_no_rvalid", cpu_rvalid, 32'h0);
        chk("t6_led", led, 32'h0);
        chk("t6_rdata", cpu_rdata, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_idle", {cpu_stall, cpu_rvalid}, 32'h2);
        tick();
        chk("t6_reissue_rvalid", cpu_rvalid, 32'h1);
        tick();
        cpu_mem_read = 1'b0;
        #1;
        chk("t6_reissue_data", cpu_rdata, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
